// File: rtl/hazard_unit_sb.sv
// hazard_unit_sb
// Hazard unit for the 5-stage pipeline with a per-register busy scoreboard
// for a decoupled, out-of-order-writeback MUL/DIV unit.
//
// Ports
//   clk, rst                 pipeline clock, async active-high reset
//   rs1_D/rs2_D/rd_D, md_op_D  D-stage operands, MUL/DIV flag
//   rs1_E/rs2_E/rd_E         E-stage registers
//   MemtoregE, md_issue_E    E-stage load flag, MUL/DIV handoff this cycle
//   rd_M/regwrite_M, rd_W/regwrite_W  writeback info for forwarding
//   PCSrc_E                  nonzero = redirect resolved in E
//   md_wb_valid, md_wb_rd    MD unit register write this cycle
//   StallF/StallD/FlushD/FlushE  pipeline control
//   ForwardAE/ForwardBE      10 = from M, 01 = from W, 00 = regfile
//   md_cnt                   MD ops in flight
//   sb_err                   sticky protocol error
//   stall_cnt/flush_cnt      saturating performance counters
module hazard_unit_sb #(
  parameter int AW       = 5,
  parameter int MD_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [AW-1:0]                     rs1_D,
  input  logic [AW-1:0]                     rs2_D,
  input  logic [AW-1:0]                     rd_D,
  input  logic                              md_op_D,
  input  logic [AW-1:0]                     rs1_E,
  input  logic [AW-1:0]                     rs2_E,
  input  logic [AW-1:0]                     rd_E,
  input  logic                              MemtoregE,
  input  logic                              md_issue_E,
  input  logic [AW-1:0]                     rd_M,
  input  logic [AW-1:0]                     rd_W,
  input  logic                              regwrite_M,
  input  logic                              regwrite_W,
  input  logic [1:0]                        PCSrc_E,
  input  logic                              md_wb_valid,
  input  logic [AW-1:0]                     md_wb_rd,
  output logic                              StallF,
  output logic                              StallD,
  output logic                              FlushD,
  output logic                              FlushE,
  output logic [1:0]                        ForwardAE,
  output logic [1:0]                        ForwardBE,
  output logic [$clog2(MD_DEPTH+1)-1:0]     md_cnt,
  output logic                              sb_err,
  output logic [CNT_W-1:0]                  stall_cnt,
  output logic [CNT_W-1:0]                  flush_cnt
);

  localparam int NREG = 1 << AW;
  localparam int CW   = $clog2(MD_DEPTH + 1);
  localparam logic [CW-1:0] C_FULL    = CW'(MD_DEPTH);
  localparam logic [CW-1:0] C_FULL_M1 = CW'(MD_DEPTH - 1);

  logic [NREG-1:0]  r_busy;
  logic [CW-1:0]    r_md_cnt;
  logic             r_sb_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [NREG-1:0]  w_issue_mask;
  logic [NREG-1:0]  w_beff;
  logic [NREG-1:0]  w_busy_nxt;
  logic [CW-1:0]    w_md_cnt_nxt;
  logic             w_cnt_err;
  logic             w_wb_err;
  logic             w_sb_haz;
  logic             w_struct_haz;
  logic             w_lu_haz;
  logic             w_hazard;
  logic             w_redirect;

  // A register issued to the MD unit this cycle counts as busy immediately,
  // so a dependent instruction already sitting in D is held.
  always_comb begin
    w_issue_mask = '0;
    if (md_issue_E) w_issue_mask = {{(NREG-1){1'b0}}, 1'b1} << rd_E;
    w_beff    = r_busy | w_issue_mask;
    w_beff[0] = 1'b0;
  end

  assign w_sb_haz     = w_beff[rs1_D] | w_beff[rs2_D] | w_beff[rd_D];
  assign w_struct_haz = md_op_D & ((r_md_cnt == C_FULL) |
                                   ((r_md_cnt == C_FULL_M1) & md_issue_E));
  assign w_lu_haz     = MemtoregE & (rd_E != '0) & ((rd_E == rs1_D) | (rd_E == rs2_D));
  assign w_hazard     = w_sb_haz | w_struct_haz | w_lu_haz;
  assign w_redirect   = |PCSrc_E;

  // Redirect dominates: the stalled instruction is on the wrong path anyway.
  assign StallF = ~rst & w_hazard & ~w_redirect;
  assign StallD = ~rst & w_hazard & ~w_redirect;
  assign FlushD = ~rst & w_redirect;
  assign FlushE = ~rst & (w_hazard | w_redirect);

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      if (regwrite_M && rd_M != '0 && rd_M == rs1_E)      ForwardAE = 2'b10;
      else if (regwrite_W && rd_W != '0 && rd_W == rs1_E) ForwardAE = 2'b01;
      if (regwrite_M && rd_M != '0 && rd_M == rs2_E)      ForwardBE = 2'b10;
      else if (regwrite_W && rd_W != '0 && rd_W == rs2_E) ForwardBE = 2'b01;
    end
  end

  // Set after clear so an issue to the register being written back wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (md_wb_valid) w_busy_nxt[md_wb_rd] = 1'b0;
    if (md_issue_E && rd_E != '0) w_busy_nxt[rd_E] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_md_cnt_nxt = r_md_cnt;
    w_cnt_err    = 1'b0;
    if (md_issue_E && !md_wb_valid) begin
      if (r_md_cnt == C_FULL) w_cnt_err = 1'b1;
      else                    w_md_cnt_nxt = r_md_cnt + CW'(1);
    end else if (md_wb_valid && !md_issue_E) begin
      if (r_md_cnt == '0) w_cnt_err = 1'b1;
      else                w_md_cnt_nxt = r_md_cnt - CW'(1);
    end
  end

  assign w_wb_err = md_wb_valid & (md_wb_rd != '0) & ~r_busy[md_wb_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= '0;
      r_md_cnt    <= '0;
      r_sb_err    <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_busy   <= w_busy_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      if (w_cnt_err || w_wb_err) r_sb_err <= 1'b1;
      if (StallD && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (FlushD && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign md_cnt    = r_md_cnt;
  assign sb_err    = r_sb_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit_sb.sv
module tb_hazard_unit_sb;

  localparam int AW = 5;
  localparam int MD_DEPTH = 2;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E, rd_M, rd_W, md_wb_rd;
  logic md_op_D, MemtoregE, md_issue_E, regwrite_M, regwrite_W, md_wb_valid;
  logic [1:0] PCSrc_E;
  logic StallF, StallD, FlushD, FlushE, sb_err;
  logic [1:0] ForwardAE, ForwardBE;
  logic [1:0] md_cnt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_unit_sb #(.AW(AW), .MD_DEPTH(MD_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .md_op_D(md_op_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .MemtoregE(MemtoregE), .md_issue_E(md_issue_E),
    .rd_M(rd_M), .rd_W(rd_W), .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
    .PCSrc_E(PCSrc_E), .md_wb_valid(md_wb_valid), .md_wb_rd(md_wb_rd),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .md_cnt(md_cnt), .sb_err(sb_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic clear_inputs();
    rs1_D = '0; rs2_D = '0; rd_D = '0; md_op_D = 0;
    rs1_E = '0; rs2_E = '0; rd_E = '0; MemtoregE = 0; md_issue_E = 0;
    rd_M = '0; rd_W = '0; regwrite_M = 0; regwrite_W = 0;
    PCSrc_E = 2'b00; md_wb_valid = 0; md_wb_rd = '0;
  endtask

  // Leaves the bench 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control outputs packed as {StallF,StallD,FlushD,FlushE}.
  task automatic test_reset();
    clear_inputs();
    PCSrc_E = 2'b01; MemtoregE = 1; rd_E = 5'd5; rs1_D = 5'd5;
    regwrite_M = 1; rd_M = 5'd3; rs1_E = 5'd3;
    #2;
    n_vec++;
    if ({StallF, StallD, FlushD, FlushE, ForwardAE} !== 6'b0) begin
      n_err++; $display("FAIL rst_outputs_forced: got %b exp 000000",
                        {StallF, StallD, FlushD, FlushE, ForwardAE});
    end
    tick();
    rst = 0;
    clear_inputs();
    #1;
    n_vec++;
    if ({StallF, StallD, FlushD, FlushE, md_cnt, sb_err} !== 7'b0 ||
        stall_cnt !== 0 || flush_cnt !== 0) begin
      n_err++; $display("FAIL post_reset_state: ctl=%b md_cnt=%0d sb_err=%b stall=%0d flush=%0d exp all 0",
                        {StallF, StallD, FlushD, FlushE}, md_cnt, sb_err, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    MemtoregE = 1; rd_E = 5'd5; rs1_D = 5'd5;
    #1;
    n_vec++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
      n_err++; $display("FAIL lu_stall: got %b exp 1101", {StallF, StallD, FlushD, FlushE});
    end
    tick();
    clear_inputs();
    MemtoregE = 1; rd_E = 5'd0; rs1_D = 5'd0;
    #1;
    n_vec++;
    if (stall_cnt !== 32'd1) begin
      n_err++; $display("FAIL lu_stall_cnt: got %0d exp 1", stall_cnt);
    end
    n_vec++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
      n_err++; $display("FAIL lu_rd0_nostall: got %b exp 0000", {StallF, StallD, FlushD, FlushE});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_md_raw();
    md_issue_E = 1; rd_E = 5'd7; rs2_D = 5'd7;
    #1;
    n_vec++;
    if (StallD !== 1'b1) begin
      n_err++; $display("FAIL raw_issue_cycle: StallD got %b exp 1", StallD);
    end
    tick();
    md_issue_E = 0; rd_E = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if (StallD !== 1'b1 || md_cnt !== 2'd1) begin
        n_err++; $display("FAIL raw_wait_%0d: StallD=%b md_cnt=%0d exp 1/1", i, StallD, md_cnt);
      end
      tick();
    end
    md_wb_valid = 1; md_wb_rd = 5'd7;
    #1;
    n_vec++;
    if (StallD !== 1'b1) begin
      n_err++; $display("FAIL raw_wb_cycle: StallD got %b exp 1", StallD);
    end
    tick();
    md_wb_valid = 0; md_wb_rd = '0;
    #1;
    n_vec++;
    if (StallD !== 1'b0 || md_cnt !== 2'd0 || sb_err !== 1'b0 || stall_cnt !== 32'd5) begin
      n_err++; $display("FAIL raw_release: StallD=%b md_cnt=%0d sb_err=%b stall_cnt=%0d exp 0/0/0/5",
                        StallD, md_cnt, sb_err, stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_forward();
    regwrite_M = 1; regwrite_W = 1; rd_M = 5'd9; rd_W = 5'd9; rs1_E = 5'd9;
    rs2_E = 5'd0;
    #1;
    n_vec++;
    if (ForwardAE !== 2'b10) begin
      n_err++; $display("FAIL fwd_m_priority: ForwardAE got %b exp 10", ForwardAE);
    end
    regwrite_M = 0;
    #1;
    n_vec++;
    if (ForwardAE !== 2'b01) begin
      n_err++; $display("FAIL fwd_w: ForwardAE got %b exp 01", ForwardAE);
    end
    regwrite_M = 1; rd_M = 5'd0;
    #1;
    n_vec++;
    if (ForwardBE !== 2'b00 || ForwardAE !== 2'b01) begin
      n_err++; $display("FAIL fwd_x0: AE=%b BE=%b exp 01/00", ForwardAE, ForwardBE);
    end
    rd_M = 5'd4; rs2_E = 5'd4; rd_W = 5'd12; rs1_E = 5'd13;
    #1;
    n_vec++;
    if (ForwardAE !== 2'b00 || ForwardBE !== 2'b10) begin
      n_err++; $display("FAIL fwd_independent: AE=%b BE=%b exp 00/10", ForwardAE, ForwardBE);
    end
    clear_inputs();
  endtask

  task automatic test_structural();
    md_issue_E = 1; rd_E = 5'd3;
    tick();
    md_issue_E = 1; rd_E = 5'd4; md_op_D = 1;
    #1;
    n_vec++;
    if (StallD !== 1'b1 || md_cnt !== 2'd1) begin
      n_err++; $display("FAIL struct_lookahead: StallD=%b md_cnt=%0d exp 1/1", StallD, md_cnt);
    end
    tick();
    md_issue_E = 0; rd_E = '0;
    #1;
    n_vec++;
    if (StallD !== 1'b1 || md_cnt !== 2'd2) begin
      n_err++; $display("FAIL struct_full: StallD=%b md_cnt=%0d exp 1/2", StallD, md_cnt);
    end
    tick();
    md_wb_valid = 1; md_wb_rd = 5'd3;
    tick();
    md_wb_valid = 0; md_wb_rd = '0;
    #1;
    n_vec++;
    if (StallD !== 1'b0 || md_cnt !== 2'd1 || stall_cnt !== 32'd8) begin
      n_err++; $display("FAIL struct_release: StallD=%b md_cnt=%0d stall_cnt=%0d exp 0/1/8",
                        StallD, md_cnt, stall_cnt);
    end
    md_op_D = 0; md_wb_valid = 1; md_wb_rd = 5'd4;
    tick();
    clear_inputs();
    #1;
    n_vec++;
    if (md_cnt !== 2'd0 || sb_err !== 1'b0) begin
      n_err++; $display("FAIL struct_drain: md_cnt=%0d sb_err=%b exp 0/0", md_cnt, sb_err);
    end
  endtask

  task automatic test_redirect();
    MemtoregE = 1; rd_E = 5'd5; rs1_D = 5'd5; PCSrc_E = 2'b01;
    #1;
    n_vec++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
      n_err++; $display("FAIL redirect_wins: got %b exp 0011", {StallF, StallD, FlushD, FlushE});
    end
    tick();
    clear_inputs();
    #1;
    n_vec++;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd8) begin
      n_err++; $display("FAIL redirect_counters: flush=%0d stall=%0d exp 1/8", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_wb_error();
    md_wb_valid = 1; md_wb_rd = 5'd12;
    #1;
    n_vec++;
    if (sb_err !== 1'b0) begin
      n_err++; $display("FAIL wb_err_early: sb_err got %b exp 0", sb_err);
    end
    tick();
    clear_inputs();
    tick();
    n_vec++;
    if (sb_err !== 1'b1 || md_cnt !== 2'd0) begin
      n_err++; $display("FAIL wb_err_sticky: sb_err=%b md_cnt=%0d exp 1/0", sb_err, md_cnt);
    end
  endtask

  task automatic test_reset_mid();
    md_issue_E = 1; rd_E = 5'd10;
    tick();
    clear_inputs();
    rs1_D = 5'd10;
    #1;
    n_vec++;
    if (StallD !== 1'b1 || md_cnt !== 2'd1) begin
      n_err++; $display("FAIL mid_pre_stall: StallD=%b md_cnt=%0d exp 1/1", StallD, md_cnt);
    end
    rst = 1;
    #1;
    n_vec++;
    if ({StallF, StallD, FlushD, FlushE, md_cnt, sb_err} !== 7'b0 ||
        stall_cnt !== 0 || flush_cnt !== 0) begin
      n_err++; $display("FAIL mid_reset_outputs: ctl=%b md_cnt=%0d sb_err=%b stall=%0d flush=%0d exp all 0",
                        {StallF, StallD, FlushD, FlushE}, md_cnt, sb_err, stall_cnt, flush_cnt);
    end
    tick();
    rst = 0;
    #1;
    n_vec++;
    if (StallD !== 1'b0) begin
      n_err++; $display("FAIL mid_busy_discarded: StallD got %b exp 0", StallD);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    md_issue_E = 1; rd_E = 5'd1;
    tick();
    rd_E = 5'd2;
    tick();
    rd_E = 5'd3; md_wb_valid = 1; md_wb_rd = 5'd1;
    tick();
    md_wb_valid = 0; md_wb_rd = '0;
    rd_E = '0; md_issue_E = 0;
    #1;
    n_vec++;
    if (md_cnt !== 2'd2 || sb_err !== 1'b0) begin
      n_err++; $display("FAIL b2b_issue_wb: md_cnt=%0d sb_err=%b exp 2/0", md_cnt, sb_err);
    end
    rs1_D = 5'd1; rs2_D = 5'd3;
    #1;
    n_vec++;
    if (StallD !== 1'b1) begin
      n_err++; $display("FAIL b2b_x3_busy: StallD got %b exp 1", StallD);
    end
    rs2_D = 5'd0;
    #1;
    n_vec++;
    if (StallD !== 1'b0) begin
      n_err++; $display("FAIL b2b_x1_free: StallD got %b exp 0", StallD);
    end
    clear_inputs();
    md_issue_E = 1; rd_E = 5'd5;
    tick();
    clear_inputs();
    #1;
    n_vec++;
    if (md_cnt !== 2'd2 || sb_err !== 1'b1) begin
      n_err++; $display("FAIL b2b_overflow: md_cnt=%0d sb_err=%b exp 2/1", md_cnt, sb_err);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_md_raw();
    test_forward();
    test_structural();
    test_redirect();
    test_wb_error();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_unit_sb.md
# hazard_unit_sb

Scoreboarded hazard unit for the 5-stage pipelined RISC-V core. It generalises load-use stalling, E-stage forwarding and branch flushing to a parametrised register file. It adds a per-register busy scoreboard and an outstanding-operation counter for a decoupled multi-cycle MUL/DIV unit that writes back out of order with the main pipeline. Saturating performance counters record stall and flush cycles.

## Interface
- AW, 5, register address width; NREG = 2^AW scoreboard entries
- MD_DEPTH, 4, maximum multi-cycle ops in flight (≥1)
- CNT_W, 32, performance counter width
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset; one clock, asynchronous and active-high
- rs1_D, rs2_D, rd_D  in  AW each  D-stage source/destination registers
- md_op_D  in  1  D-stage instruction is MUL/DIV
- rs1_E, rs2_E, rd_E  in  AW each  E-stage registers
- MemtoregE  in  1  E-stage instruction is a load
- md_issue_E  in  1  E-stage MUL/DIV is handed to the MD unit this cycle
- rd_M, rd_W  in  AW each; regwrite_M, regwrite_W  in  1 each  M/W writeback info
- PCSrc_E  in  2  nonzero = redirect resolved in E
- md_wb_valid  in  1; md_wb_rd  in  AW  MD unit writes md_wb_rd this cycle
- StallF, StallD, FlushD, FlushE  out  1 each
- ForwardAE, ForwardBE  out  2 each  00 regfile, 10 from M, 01 from W
- md_cnt  out  clog2(MD_DEPTH+1)  ops in flight
- sb_err  out  1  sticky protocol error
- stall_cnt, flush_cnt  out  CNT_W each

## Operation
- State: busy[NREG-1:0], md_cnt, sb_err, stall_cnt, flush_cnt. All are registered; all are cleared on rst.
- Busy effective: beff[r] = busy[r] | (md_issue_E & rd_E==r). Register r=0 is never busy.
- Scoreboard hazard: D instruction has rs1_D, rs2_D or rd_D (WAW) with beff set, and that register is ≠0.
- Structural hazard: md_op_D & (md_cnt==MD_DEPTH | (md_cnt==MD_DEPTH-1 & md_issue_E)).
- Load-use: MemtoregE & rd_E≠0 & (rd_E==rs1_D | rd_E==rs2_D).
- Any hazard: StallF=StallD=FlushE=1.
- Redirect (PCSrc_E≠0) overrides all: FlushD=FlushE=1 and StallF=StallD=0.
- Forwarding for rs1_E and rs2_E (independent paths):
  - 10 if regwrite_M & rd_M≠0 & match;
  - else 01 if regwrite_W & rd_W≠0 & match;
  - else 00.
  - No forwarding from the MD unit. The scoreboard keeps the consumer in D until the regfile holds the value.
- Busy update:
  - md_wb_valid clears busy[md_wb_rd].
  - md_issue_E & rd_E≠0 sets busy[rd_E].
  - Same register both: set wins.
- md_cnt: +1 on md_issue_E, -1 on md_wb_valid; both at once means unchanged. Increment past MD_DEPTH or decrement below 0 sets sb_err and leaves the count held.
- sb_err also sets on md_wb_valid with md_wb_rd≠0 and busy[md_wb_rd]=0. Only rst clears sb_err.
- stall_cnt increments each cycle StallD=1. flush_cnt increments each cycle FlushD=1. Both saturate at 2^CNT_W-1.

## Timing
- Stall, flush and forward outputs are combinational from inputs and current state; there is no added latency.
- Scoreboard and counter changes take effect on the next rising edge after the causing event.
- Busy clears at the same edge as the MD regfile write. The D consumer is released the cycle after md_wb_valid and reads the written value.
- While rst=1, all outputs are forced to 0. After rst, all registers are 0 and the first cycle has no stalls from scoreboard state.
- Reset mid-operation discards all busy bits and in-flight counts. The MD unit is reset by the same rst.
- Redirect plus hazard in the same cycle: redirect outputs only; stall_cnt does not increment; flush_cnt increments.

## Test plan
- Load-use: MemtoregE=1, rd_E=5, rs1_D=5 → StallF=StallD=FlushE=1 for one cycle, stall_cnt=1. With rd_E=0, no stall.
- MD RAW: issue rd_E=7 (md_issue_E=1) while rs2_D=7 → stall that cycle and every cycle until md_wb_valid with md_wb_rd=7. Stall drops the next cycle; busy[7]=0.
- Structural: MD_DEPTH=2, issue two ops to x3 and x4, then md_op_D=1 → stall. Writeback of x3 → md_cnt=1; stall releases the next cycle.
- Forward priority: regwrite_M=regwrite_W=1, rd_M=rd_W=rs1_E=9 → ForwardAE=10. regwrite_M=0 → 01. rs2_E=0 with rd_M=0 → ForwardBE=00.
- Redirect wins: PCSrc_E=01 with load-use hazard active → FlushD=FlushE=1, StallF=StallD=0, flush_cnt +1.
- Errors and reset: md_wb_valid for non-busy x12 → sb_err=1 next edge. Assert rst mid-stall → all outputs 0 immediately, md_cnt=0, sb_err=0.
